// File: rtl/i15341_core_pkg.sv
// Shared constants for the i15341 benchmark leaf: the 3-input function as a
// lookup table, the trigger word that toggles the state bit, and reset values.
package i15341_core_pkg;

    // Stimulus word ordered {N0, N1, N2}; N0 is the MSB.
    typedef logic [2:0] in_word_t;

    // f = (N0 & ~N1) | (N1 & N2), indexed by {N0,N1,N2}; bit 7 is word 111.
    localparam logic [7:0] F_TABLE   = 8'b1011_1000;

    // Word that flips the state bit when sampled on a rising edge.
    localparam in_word_t   TRIG_CODE = 3'b111;

    // Values forced by reset.
    localparam logic       Q_RST     = 1'b0;
    localparam logic       OUT_RST   = 1'b0;

    // Combinational core evaluated from the table.
    function automatic logic f_lookup(input in_word_t word);
        return F_TABLE[word];
    endfunction

endpackage

// File: rtl/i15341_toggle_flop.sv
// Single toggle state bit: flips on every rising edge where t is high,
// cleared asynchronously by rst.
module i15341_toggle_flop
    import i15341_core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_reg;

    // Toggle register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= Q_RST;
        end else begin
            q_reg <= q_reg ^ t;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/i15341_core.sv
// i15341 benchmark leaf: registered XOR of a fixed 3-input function and a
// toggle state bit that flips whenever input word 111 is sampled.
module i15341_core
    import i15341_core_pkg::*;
(
    input  logic CK,
    input  logic reset,
    input  logic N0,
    input  logic N1,
    input  logic N2,
    output logic output_single
);

    in_word_t word;
    logic     f;
    logic     t;
    logic     q;
    logic     out_reg;

    assign word = {N0, N1, N2};
    assign f    = f_lookup(word);
    assign t    = (word == TRIG_CODE);

    // The output flop sees q before this edge's toggle, because both
    // registers update on the same edge.
    i15341_toggle_flop u_toggle (
        .clk (CK),
        .rst (reset),
        .t   (t),
        .q   (q)
    );

    // Output register: driven straight from a flop so it is glitch-free.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            out_reg <= OUT_RST;
        end else begin
            out_reg <= f ^ q;
        end
    end

    assign output_single = out_reg;

endmodule

// File: tb/tb_i15341_core.sv
// Directed bench for i15341_core with hand-computed expected outputs.
`timescale 1ns/1ps
module tb_i15341_core;

    logic CK;
    logic reset;
    logic N0, N1, N2;
    logic output_single;

    int n_checks;
    int n_fail;

    i15341_core dut (
        .CK            (CK),
        .reset         (reset),
        .N0            (N0),
        .N1            (N1),
        .N2            (N2),
        .output_single (output_single)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end else begin
            $display("ok   %s: observed=%b at %0t", tag, observed, $time);
        end
    endtask

    // Drive a word at the falling edge, check the output just after the next rising edge.
    task automatic apply(input logic [2:0] w, input logic expected, input string tag);
        @(negedge CK);
        {N0, N1, N2} = w;
        @(posedge CK);
        #1;
        check_bit(tag, output_single, expected);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        {N0, N1, N2} = 3'b011;   // f=1, would set output if reset were ignored

        #1;
        check_bit("reset_async_initial", output_single, 1'b0);
        @(posedge CK); #1;
        check_bit("reset_held_edge1", output_single, 1'b0);
        @(posedge CK); #1;
        check_bit("reset_held_edge2", output_single, 1'b0);
        @(negedge CK);
        reset = 1'b0;

        // Sweep with q=0.
        apply(3'b000, 1'b0, "sweep_000");
        apply(3'b001, 1'b0, "sweep_001");
        apply(3'b010, 1'b0, "sweep_010");
        apply(3'b011, 1'b1, "sweep_011");
        apply(3'b100, 1'b1, "sweep_100");
        apply(3'b101, 1'b1, "sweep_101");
        apply(3'b110, 1'b0, "sweep_110");

        // Trigger with q=0: out = 1^0, q -> 1.
        apply(3'b111, 1'b1, "trig_q0");
        // Inverted: q=1.
        apply(3'b011, 1'b0, "inv_011");
        apply(3'b000, 1'b1, "inv_000");
        // 111 with q=1: out = 1^1 = 0, q -> 0.
        apply(3'b111, 1'b0, "trig_q1");

        // Double trigger from q=0.
        apply(3'b111, 1'b1, "dbl_first");
        apply(3'b111, 1'b0, "dbl_second");
        apply(3'b100, 1'b1, "dbl_after_100");

        // Input change between edges has no effect on the output.
        #2;
        {N0, N1, N2} = 3'b000;
        #1;
        check_bit("midcycle_hold", output_single, 1'b1);

        // Set q=1, output=1, then pulse reset between edges.
        apply(3'b111, 1'b1, "pre_reset_trig");
        #1;
        reset = 1'b1;
        #1;
        check_bit("async_reset_drop", output_single, 1'b0);
        reset = 1'b0;
        apply(3'b011, 1'b1, "post_reset_011");
        apply(3'b000, 1'b0, "post_reset_000");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
